// File: rtl/output_drain.sv
// Output stage between the convolution core and the shared buses: buffers result
// pixels in a small FIFO and streams them onto bus_1 when the host releases the buses.
module output_drain #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 8,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic                                  start,
  input  logic [CNT_WIDTH-1:0]                  expected_outputs,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] in_ch,
  input  logic                                  host_bus_req,
  output logic                                  dut_driving_busses,
  output logic [DATA_WIDTH-1:0]                 to_bus_1,
  output logic [DATA_WIDTH-1:0]                 to_bus_2,
  output logic [DATA_WIDTH-1:0]                 to_bus_3,
  output logic                                  output_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic                                  done
);

  localparam int XW   = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW   = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CHW  = $clog2(OUTPUT_NB_CHANNELS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int OCW  = PW + 1;

  localparam logic [OCW-1:0]       DEPTH_C   = OCW'(FIFO_DEPTH);
  localparam logic [OCW-1:0]       OCC_ONE   = OCW'(1);
  localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] DRAIN_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [CHW-1:0]        ch;
  } entry_t;

  entry_t                mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [OCW-1:0]        count_r;
  logic [OCW-1:0]        count_next_s;
  logic                  in_ready_r;

  state_t                state_r;
  state_t                next_state_s;
  logic                  drive_r;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] bus1_r;
  logic [XW-1:0]         x_r;
  logic [YW-1:0]         y_r;
  logic [CHW-1:0]        ch_r;

  logic [CNT_WIDTH-1:0]  expected_r;
  logic [CNT_WIDTH-1:0]  drained_r;
  logic [CNT_WIDTH-1:0]  drained_inc_s;
  logic                  done_r;
  logic                  fired_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  has_data_s;
  entry_t                head_s;

  assign push_s        = in_valid && in_ready_r;
  assign has_data_s    = (count_r != {OCW{1'b0}});
  assign pop_s         = (state_r == DRIVE) && (next_state_s == DRIVE);
  assign head_s        = mem_r[rd_ptr_r];
  assign drained_inc_s = (drained_r == DRAIN_MAX) ? DRAIN_MAX : (drained_r + DRAIN_ONE);

  // Bus turnaround sequencing; host request always wins over draining.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (has_data_s && !host_bus_req) next_state_s = TURN_ON;
        else                             next_state_s = IDLE;
      end
      TURN_ON: next_state_s = DRIVE;
      DRIVE: begin
        if (has_data_s && !host_bus_req) next_state_s = DRIVE;
        else                             next_state_s = TURN_OFF;
      end
      TURN_OFF: next_state_s = IDLE;
      default:  next_state_s = IDLE;
    endcase
  end

  // Next FIFO occupancy.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s)      count_next_s = count_r + OCC_ONE;
    else if (pop_s && !push_s) count_next_s = count_r - OCC_ONE;
    else                       count_next_s = count_r;
  end

  // FIFO storage, pointers and occupancy; ready is registered so it is low in reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {OCW{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{data: in_data, x: in_x, y: in_y, ch: in_ch};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s < DEPTH_C);
    end
  end

  // FSM state with registered bus enable and output beat.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
      drive_r <= 1'b0;
      valid_r <= 1'b0;
      bus1_r  <= {DATA_WIDTH{1'b0}};
      x_r     <= {XW{1'b0}};
      y_r     <= {YW{1'b0}};
      ch_r    <= {CHW{1'b0}};
    end else begin
      state_r <= next_state_s;
      drive_r <= (next_state_s == TURN_ON) || (next_state_s == DRIVE);
      valid_r <= pop_s;
      if (pop_s) begin
        bus1_r <= head_s.data;
        x_r    <= head_s.x;
        y_r    <= head_s.y;
        ch_r   <= head_s.ch;
      end else begin
        bus1_r <= {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Layer progress: count delivered beats and fire done once per start.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      expected_r <= {CNT_WIDTH{1'b0}};
      drained_r  <= {CNT_WIDTH{1'b0}};
      done_r     <= 1'b0;
      fired_r    <= 1'b0;
    end else if (start) begin
      expected_r <= expected_outputs;
      drained_r  <= {CNT_WIDTH{1'b0}};
      done_r     <= 1'b0;
      fired_r    <= 1'b0;
    end else if (valid_r) begin
      drained_r <= drained_inc_s;
      if (!fired_r && (expected_r != {CNT_WIDTH{1'b0}}) && (drained_inc_s == expected_r)) begin
        done_r  <= 1'b1;
        fired_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign in_ready           = in_ready_r;
  assign dut_driving_busses = drive_r;
  assign output_valid       = valid_r;
  assign to_bus_1           = bus1_r;
  assign to_bus_2           = {DATA_WIDTH{1'b0}};
  assign to_bus_3           = {DATA_WIDTH{1'b0}};
  assign output_x           = x_r;
  assign output_y           = y_r;
  assign output_ch          = ch_r;
  assign fifo_count         = count_r;
  assign done               = done_r;

endmodule

// File: tb/tb_output_drain.sv
// Directed bench for output_drain: stimulus pushes expected beats into a scoreboard
// queue, a negedge monitor pops and compares each output_valid beat.
module tb_output_drain;

  typedef struct packed {
    logic [15:0] d;
    logic [6:0]  x;
    logic [6:0]  y;
    logic [5:0]  c;
  } beat_t;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [31:0] expected_outputs;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [6:0]  in_x;
  logic [6:0]  in_y;
  logic [5:0]  in_ch;
  logic        host_bus_req;
  logic        dut_driving_busses;
  logic [15:0] to_bus_1;
  logic [15:0] to_bus_2;
  logic [15:0] to_bus_3;
  logic        output_valid;
  logic [6:0]  output_x;
  logic [6:0]  output_y;
  logic [5:0]  output_ch;
  logic [3:0]  fifo_count;
  logic        done;

  int    errors = 0;
  int    checks = 0;
  int    done_pulses = 0;
  beat_t sb_q[$];
  beat_t mon_exp;

  output_drain dut (
    .clk(clk), .arst_n(arst_n), .start(start), .expected_outputs(expected_outputs),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .host_bus_req(host_bus_req),
    .dut_driving_busses(dut_driving_busses), .to_bus_1(to_bus_1),
    .to_bus_2(to_bus_2), .to_bus_3(to_bus_3), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .fifo_count(fifo_count), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every beat must match the oldest accepted entry.
  always @(negedge clk) begin
    if (arst_n && output_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %h/%0d/%0d/%0d, queue empty",
                 to_bus_1, output_x, output_y, output_ch);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({to_bus_1, output_x, output_y, output_ch} !== mon_exp) begin
          errors++;
          $display("FAIL beat_data: got %h/%0d/%0d/%0d expected %h/%0d/%0d/%0d",
                   to_bus_1, output_x, output_y, output_ch,
                   mon_exp.d, mon_exp.x, mon_exp.y, mon_exp.c);
        end
      end
      checks++;
      if (!dut_driving_busses) begin
        errors++;
        $display("FAIL valid_without_drive: got drive=0 expected 1");
      end
    end
    if (arst_n && done) done_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [6:0] x, input logic [6:0] y,
                      input logic [5:0] c);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_x = x; in_y = y; in_ch = c;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0;
    end else begin
      tick();
      sb_q.push_back(beat_t'({d, x, y, c}));
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((fifo_count != 4'd0 || dut_driving_busses || output_valid) && n < 200) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk({name, "_idle"}, {31'd0, dut_driving_busses}, 32'd0);
    chk({name, "_drained"}, sb_q.size(), 32'd0);
  endtask

  task automatic pulse_start(input logic [31:0] e);
    start = 1'b1; expected_outputs = e;
    tick();
    start = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; expected_outputs = 32'd0; in_valid = 1'b0;
    in_data = 16'd0; in_x = 7'd0; in_y = 7'd0; in_ch = 6'd0; host_bus_req = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_drive", {31'd0, dut_driving_busses}, 32'd0);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);
    chk("rst_bus2_bus3", {to_bus_2, to_bus_3}, 32'd0);
    #4 arst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, output_valid}, 32'd0);

    // Basic three-beat layer with done timing.
    pulse_start(32'd3);
    push(16'h0011, 7'd1, 7'd2, 6'd3);
    chk("t1_drive_e0", {31'd0, dut_driving_busses}, 32'd0);
    push(16'h0022, 7'd1, 7'd2, 6'd4);
    chk("t1_drive_e1", {31'd0, dut_driving_busses}, 32'd1);
    push(16'h0033, 7'd1, 7'd2, 6'd5);
    chk("t1_guard_valid", {31'd0, output_valid}, 32'd0);
    tick(); chk("t1_beat1", {31'd0, output_valid}, 32'd1);
    tick(); chk("t1_beat2", {31'd0, output_valid}, 32'd1);
    tick(); chk("t1_beat3", {31'd0, output_valid}, 32'd1);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_drive_off", {31'd0, dut_driving_busses}, 32'd0);
    tick(); chk("t1_done_once", {31'd0, done}, 32'd0);
    wait_idle("t1");

    // Fill to full under host ownership, then release.
    host_bus_req = 1'b1;
    for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i), 7'(i), 7'(i + 1), 6'(i + 2));
    chk("t2_count_full", {28'd0, fifo_count}, 32'd8);
    chk("t2_ready_low", {31'd0, in_ready}, 32'd0);
    chk("t2_no_drive", {31'd0, dut_driving_busses}, 32'd0);
    in_valid = 1'b1; in_data = 16'h0208;
    tick(); tick();
    chk("t2_no_push_full", {28'd0, fifo_count}, 32'd8);
    host_bus_req = 1'b0;
    push(16'h0208, 7'd8, 7'd9, 6'd10);
    push(16'h0209, 7'd9, 7'd10, 6'd11);
    wait_idle("t2");

    // Host request mid-drain after two beats.
    host_bus_req = 1'b1;
    for (int i = 0; i < 5; i++) push(16'h0300 + 16'(i), 7'(10 + i), 7'(20 + i), 6'(30 + i));
    host_bus_req = 1'b0;
    tick(); chk("t3_turn_on", {31'd0, dut_driving_busses}, 32'd1);
    tick(); chk("t3_guard", {31'd0, output_valid}, 32'd0);
    tick(); chk("t3_beat1", {31'd0, output_valid}, 32'd1);
    tick(); chk("t3_beat2", {31'd0, output_valid}, 32'd1);
    host_bus_req = 1'b1;
    tick();
    chk("t3_no_beat_on_req", {31'd0, output_valid}, 32'd0);
    chk("t3_drive_off", {31'd0, dut_driving_busses}, 32'd0);
    chk("t3_retained", {28'd0, fifo_count}, 32'd3);
    tick(); tick();
    chk("t3_held", {28'd0, fifo_count}, 32'd3);
    host_bus_req = 1'b0;
    tick();
    chk("t3_reon_drive", {31'd0, dut_driving_busses}, 32'd1);
    chk("t3_reon_valid", {31'd0, output_valid}, 32'd0);
    wait_idle("t3");

    // Concurrent push/pop at occupancy 4 across pointer wrap.
    host_bus_req = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h0400 + 16'(i), 7'(i), 7'(i), 6'(i));
    host_bus_req = 1'b0;
    tick(); tick();
    for (int i = 4; i < 20; i++) begin
      push(16'h0400 + 16'(i), 7'(i), 7'(i), 6'(i));
      chk("t4_count_steady", {28'd0, fifo_count}, 32'd4);
    end
    wait_idle("t4");

    // Asynchronous reset while driving with five entries.
    host_bus_req = 1'b1;
    for (int i = 0; i < 5; i++) push(16'h0500 + 16'(i), 7'(i), 7'(i), 6'(i));
    host_bus_req = 1'b0;
    tick(); tick();
    chk("t5_in_drive", {31'd0, dut_driving_busses}, 32'd1);
    arst_n = 1'b0;
    #1;
    chk("t5_rst_drive", {31'd0, dut_driving_busses}, 32'd0);
    chk("t5_rst_count", {28'd0, fifo_count}, 32'd0);
    chk("t5_rst_outs", {15'd0, output_valid, to_bus_1}, 32'd0);
    chk("t5_rst_coords", {12'd0, output_x, output_y, output_ch}, 32'd0);
    chk("t5_rst_ready", {30'd0, in_ready, done}, 32'd0);
    sb_q.delete();
    #4 arst_n = 1'b1;
    tick();
    chk("t5_post_count", {28'd0, fifo_count}, 32'd0);
    chk("t5_post_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_stays_idle", {31'd0, dut_driving_busses}, 32'd0);

    // done never fires for expected=0; fires once after a fresh start of 2.
    done_pulses = 0;
    pulse_start(32'd0);
    for (int i = 0; i < 4; i++) push(16'h0600 + 16'(i), 7'(i), 7'(i), 6'(i));
    wait_idle("t6a");
    chk("t6_no_done_zero", done_pulses, 32'd0);
    pulse_start(32'd2);
    for (int i = 0; i < 3; i++) push(16'h0700 + 16'(i), 7'(i), 7'(i), 6'(i));
    tick(); chk("t6_done_b1", {31'd0, done}, 32'd0);
    tick(); chk("t6_done_b2", {31'd0, done}, 32'd0);
    tick(); chk("t6_done", {31'd0, done}, 32'd1);
    tick(); chk("t6_done_pulse", {31'd0, done}, 32'd0);
    wait_idle("t6b");
    chk("t6_done_count", done_pulses, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
